// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x32 register file and its readback engine.
//   DATA_WIDTH / ADDR_WIDTH : register word and address widths
//   CNT_WIDTH               : width of a word count covering 1..2^ADDR_WIDTH
//   dump_state_t            : dump sequencer states
//   range_len()             : word count of an inclusive, wrapping address range
package regfile_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } dump_state_t;

  // The subtraction wraps in ADDR_WIDTH bits, so first > last walks through the top
  // of the file; first == last gives one word, a full wrap gives 2^ADDR_WIDTH words.
  function automatic logic [CNT_WIDTH-1:0] range_len(input logic [ADDR_WIDTH-1:0] first,
                                                     input logic [ADDR_WIDTH-1:0] last);
    logic [ADDR_WIDTH-1:0] span;
    span = last - first;
    return {1'b0, span} + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Readback sequencer for the register file. A Start pulse in IDLE walks the inclusive,
// wrapping range FirstAdd..LastAdd over one read port, streams each word with its
// address on a valid/ready interface and accumulates an XOR checksum.
// Ports:
//   clk, Reset            : clock, synchronous active-low reset
//   Start, FirstAdd/LastAdd : dump request and range, sampled only in IDLE
//   RdAdd / RdData        : register file read port (combinational read)
//   OutData/OutAdd/OutValid/OutReady : output word stream
//   Busy, Done            : dump in progress, one-cycle completion pulse
//   Checksum              : XOR of every word loaded this dump, held after Done
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] FirstAdd,
  input  logic [ADDR_WIDTH-1:0] LastAdd,
  output logic [ADDR_WIDTH-1:0] RdAdd,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [ADDR_WIDTH-1:0] OutAdd,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Checksum
);

  dump_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_add_q, out_add_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  logic handshake;
  logic load;

  assign handshake = out_valid_q & OutReady;
  // A word may be loaded whenever the output slot is empty or is being drained.
  assign load = (state_q == RUN) && (remaining_q != '0) && (!out_valid_q || OutReady);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_add_d   = out_add_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    checksum_d  = checksum_q;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          ptr_d       = FirstAdd;
          remaining_d = range_len(FirstAdd, LastAdd);
          checksum_d  = '0;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (load) begin
          out_data_d  = RdData;
          out_add_d   = ptr_q;
          out_valid_d = 1'b1;
          ptr_d       = ptr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - CNT_WIDTH'(1);
          checksum_d  = checksum_q ^ RdData;
        end else if (handshake) begin
          out_valid_d = 1'b0;
        end
        // Nothing left to load and the output slot is empty or draining now.
        if ((remaining_q == '0) && (handshake || !out_valid_q)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_add_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_add_q   <= out_add_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      checksum_q  <= checksum_d;
    end
  end

  assign RdAdd    = ptr_q;
  assign OutData  = out_data_q;
  assign OutAdd   = out_add_q;
  assign OutValid = out_valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Checksum = checksum_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a behavioural register file (combinational read,
// clocked write port), a transaction-level model of the dump, directed scenarios with
// literal expectations and a randomized phase with backpressure, writes and resets.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset, Start, OutReady, OutValid, Busy, Done;
  logic [4:0]  FirstAdd, LastAdd, RdAdd, OutAdd;
  logic [31:0] RdData, OutData, Checksum;

  regfile_dump_reader dut (
    .clk      (clk),
    .Reset    (Reset),
    .Start    (Start),
    .FirstAdd (FirstAdd),
    .LastAdd  (LastAdd),
    .RdAdd    (RdAdd),
    .RdData   (RdData),
    .OutData  (OutData),
    .OutAdd   (OutAdd),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Busy     (Busy),
    .Done     (Done),
    .Checksum (Checksum)
  );

  // Register file: writes land at the edge, reads are combinational.
  logic [31:0] mem [32];
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  always @(posedge clk) if (we) mem[wa] <= wd;
  assign RdData = mem[RdAdd];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a dump of n words from 'first'; counts of words loaded into the
  // output slot and words accepted by the consumer drive everything else.
  bit          live = 0;
  logic        m_busy, m_done, m_valid;
  logic [31:0] m_sum, m_data;
  logic [4:0]  m_ptr, m_add, span;
  int          m_n, m_loaded, m_accepted;
  bit          hs;

  logic [4:0]  hs_add[$];
  logic [31:0] hs_data[$];

  always @(posedge clk) begin
    if (!Reset) begin
      live = 1;
      m_busy = 0; m_done = 0; m_valid = 0;
      m_sum = 0; m_data = 0; m_ptr = 0; m_add = 0;
      m_n = 0; m_loaded = 0; m_accepted = 0;
    end else if (live) begin
      if (OutValid && OutReady) begin
        hs_add.push_back(OutAdd);
        hs_data.push_back(OutData);
      end
      if (m_done) begin
        m_done = 0;
      end else if (!m_busy) begin
        if (Start) begin
          span = LastAdd - FirstAdd;
          m_n = span + 1;
          m_ptr = FirstAdd;
          m_loaded = 0; m_accepted = 0; m_sum = 0;
          m_busy = 1;
        end
      end else begin
        hs = m_valid && OutReady;
        if (hs) m_accepted++;
        if (m_loaded < m_n && (!m_valid || OutReady)) begin
          m_data = mem[m_ptr];
          m_add = m_ptr;
          m_sum = m_sum ^ m_data;
          m_ptr = m_ptr + 5'd1;
          m_loaded++;
          m_valid = 1;
        end else if (hs) begin
          m_valid = 0;
        end
        if (m_accepted == m_n) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  end

  // Compare process: every output against the model, every cycle after the first reset.
  always @(negedge clk) begin
    if (live) begin
      check("busy", 32'(Busy), 32'(m_busy));
      check("done", 32'(Done), 32'(m_done));
      check("out_valid", 32'(OutValid), 32'(m_valid));
      check("out_add", 32'(OutAdd), 32'(m_add));
      check("out_data", OutData, m_data);
      check("rd_add", 32'(RdAdd), 32'(m_ptr));
      check("checksum", Checksum, m_sum);
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1; wa = a; wd = d;
    tick();
    we = 0;
  endtask

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    hs_add.delete();
    hs_data.delete();
    Start = 1; FirstAdd = f; LastAdd = l;
    tick();
    Start = 0;
  endtask

  // Waits for Done within a cycle budget, counting Busy cycles, then checks the pulse ends.
  task automatic wait_done(input int budget, output int busy_cyc);
    int n = 0;
    busy_cyc = 0;
    while (!Done && n < budget) begin
      if (Busy) busy_cyc++;
      tick();
      n++;
    end
    check("done_seen", 32'(Done), 32'd1);
    tick();
    check("done_pulse_end", 32'(Done), 32'd0);
  endtask

  int bc;

  initial begin
    Reset = 0; Start = 0; FirstAdd = 0; LastAdd = 0; OutReady = 1;
    we = 0; wa = 0; wd = 0;
    for (int i = 0; i < 32; i++) write_reg(5'(i), 32'd0);
    Reset = 1;
    tick();
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_checksum", Checksum, 32'd0);

    // Two-word dump at full rate.
    write_reg(5'd1, 32'h78493052);
    write_reg(5'd2, 32'h73245243);
    OutReady = 1;
    start_dump(5'd1, 5'd2);
    check("start_rdadd", 32'(RdAdd), 32'd1);
    wait_done(20, bc);
    check("t1_count", 32'(hs_add.size()), 32'd2);
    check("t1_add0", 32'(hs_add[0]), 32'd1);
    check("t1_data0", hs_data[0], 32'h78493052);
    check("t1_add1", 32'(hs_add[1]), 32'd2);
    check("t1_data1", hs_data[1], 32'h73245243);
    check("t1_checksum", Checksum, 32'h0B6D6211);
    check("t1_model_sum", m_sum, 32'h0B6D6211);
    check("t1_busy_cycles", 32'(bc), 32'd3);

    // Same dump with the consumer stalled while word 1 is presented.
    OutReady = 0;
    start_dump(5'd1, 5'd2);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(OutValid), 32'd1);
      check("bp_add", 32'(OutAdd), 32'd1);
      check("bp_data", OutData, 32'h78493052);
      check("bp_rdadd", 32'(RdAdd), 32'd2);
      tick();
    end
    OutReady = 1;
    wait_done(20, bc);
    check("bp_count", 32'(hs_add.size()), 32'd2);
    check("bp_add0", 32'(hs_add[0]), 32'd1);
    check("bp_add1", 32'(hs_add[1]), 32'd2);
    check("bp_checksum", Checksum, 32'h0B6D6211);

    // Wrapping range 30..1.
    write_reg(5'd30, 32'd30);
    write_reg(5'd31, 32'd31);
    write_reg(5'd0, 32'd0);
    write_reg(5'd1, 32'd1);
    start_dump(5'd30, 5'd1);
    wait_done(20, bc);
    check("wrap_count", 32'(hs_add.size()), 32'd4);
    check("wrap_a0", 32'(hs_add[0]), 32'd30);
    check("wrap_a1", 32'(hs_add[1]), 32'd31);
    check("wrap_a2", 32'(hs_add[2]), 32'd0);
    check("wrap_a3", 32'(hs_add[3]), 32'd1);
    check("wrap_d1", hs_data[1], 32'd31);
    check("wrap_checksum", Checksum, 32'd30 ^ 32'd31 ^ 32'd0 ^ 32'd1);

    // Single-word range.
    write_reg(5'd5, 32'hDEADBEEF);
    start_dump(5'd5, 5'd5);
    wait_done(20, bc);
    check("one_count", 32'(hs_add.size()), 32'd1);
    check("one_add", 32'(hs_add[0]), 32'd5);
    check("one_busy_cycles", 32'(bc), 32'd2);
    check("one_checksum", Checksum, 32'hDEADBEEF);

    // Start pulsed mid-dump is ignored.
    start_dump(5'd10, 5'd20);
    tick();
    tick();
    Start = 1; FirstAdd = 5'd3; LastAdd = 5'd4;
    tick();
    Start = 0;
    wait_done(40, bc);
    check("ign_count", 32'(hs_add.size()), 32'd11);
    check("ign_first", 32'(hs_add[0]), 32'd10);
    check("ign_last", 32'(hs_add[10]), 32'd20);

    // Reset mid-dump, with a coincident Start that must lose.
    start_dump(5'd0, 5'd31);
    for (int k = 0; k < 4; k++) tick();
    Reset = 0; Start = 1; FirstAdd = 5'd7;
    tick();
    Reset = 1; Start = 0;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_valid", 32'(OutValid), 32'd0);
    check("rst_checksum", Checksum, 32'd0);
    check("rst_data", OutData, 32'd0);
    check("rst_rdadd", 32'(RdAdd), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_no_done", 32'(Done), 32'd0);
      check("rst_idle", 32'(Busy), 32'd0);
    end

    // Full-file dump; byte patterns 0..31 XOR to zero.
    for (int i = 0; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
    start_dump(5'd0, 5'd31);
    wait_done(100, bc);
    check("full_count", 32'(hs_add.size()), 32'd32);
    for (int i = 0; i < 32; i++) begin
      check("full_add", 32'(hs_add[i]), 32'(i));
      check("full_data", hs_data[i], 32'(i) * 32'h01010101);
    end
    check("full_checksum", Checksum, 32'd0);
    check("full_busy_cycles", 32'(bc), 32'd33);

    // Randomized phase: stalls, random writes, stray Starts and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      Start    = ($urandom_range(0, 7) == 0);
      FirstAdd = 5'($urandom);
      LastAdd  = 5'($urandom);
      OutReady = ($urandom_range(0, 3) != 0);
      we       = $urandom_range(0, 1) == 1;
      wa       = 5'($urandom);
      wd       = $urandom;
      Reset    = ($urandom_range(0, 199) != 0);
      tick();
    end
    Reset = 1; Start = 0; we = 0; OutReady = 1;
    for (int k = 0; k < 40; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
